// File: rtl/rsp_status_capture.sv
// Response register image and sticky command status capture for the SD command path.
// Latency: response, status and busy updates are visible one clk_i cycle after the triggering pulse.
// Backpressure: none. Pulses are consumed as they arrive. Optional busy timeout is enabled by SDHCI_BUSY_TIMEOUT_EN.

package sdhci_pkg;
    // Encoding matches the SDHCI Command register Response Type Select field
    typedef enum logic [1:0] {
        RSP_NONE    = 2'b00,
        RSP_136     = 2'b01,
        RSP_48      = 2'b10,
        RSP_48_BUSY = 2'b11
    } response_type_e;
endpackage

module rsp_status_capture
    import sdhci_pkg::*;
#(
    parameter int unsigned  BusyDelay   = 2,
    parameter logic [15:0]  BusyTimeout = 16'hFFFF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clk_en_p_i,
    input  logic            soft_rst_i,
    input  logic            cmd_start_i,
    input  response_type_e  response_type_i,
    input  logic            crc_check_en_i,
    input  logic            index_check_en_i,
    input  logic            cmd_done_i,
    input  logic            cmd_result_valid_i,
    input  logic [119:0]    rsp_i,
    input  logic            index_error_i,
    input  logic            end_bit_error_i,
    input  logic            crc_error_i,
    input  logic            timeout_error_i,
    input  logic            sd_bus_dat0_i,
    input  logic [6:0]      status_clear_i,
    output logic [127:0]    response_o,
    output logic [6:0]      status_o,
    output logic            dat_busy_o
);

    localparam logic [15:0] BusyDelayW = 16'(BusyDelay);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_RESULT = 2'd1,
        BUSY_DELAY  = 2'd2,
        BUSY_WAIT   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    response_type_e type_q, type_d;
    logic           crc_en_q, crc_en_d;
    logic           idx_en_q, idx_en_d;
    logic [15:0]    dly_cnt_q, dly_cnt_d;
    logic [6:0]     status_q, status_d;
    logic [6:0]     status_set;
    logic [127:0]   resp_q, resp_d;
    logic [2:0]     err_set;

`ifdef SDHCI_BUSY_TIMEOUT_EN
    logic [15:0]    tmo_cnt_q, tmo_cnt_d;
`else
    // The timeout parameter has no effect when the busy timeout is compiled out
    logic           unused_busy_timeout;
    assign unused_busy_timeout = ^BusyTimeout;
`endif

    // Next-state, response image and status set/clear logic
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        crc_en_d   = crc_en_q;
        idx_en_d   = idx_en_q;
        dly_cnt_d  = dly_cnt_q;
        resp_d     = resp_q;
        status_set = 7'h00;
        err_set    = 3'b000;
`ifdef SDHCI_BUSY_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_start_i) begin
                    type_d   = response_type_i;
                    crc_en_d = crc_check_en_i;
                    idx_en_d = index_check_en_i;
                    state_d  = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                // A timeout supersedes anything else reported in the same cycle
                if (timeout_error_i) begin
                    status_set[2] = 1'b1;
                    state_d       = IDLE;
                end else if (type_q == RSP_NONE) begin
                    if (cmd_done_i) begin
                        status_set[0] = 1'b1;
                        state_d       = IDLE;
                    end
                end else if (cmd_result_valid_i) begin
                    if (type_q == RSP_136) begin
                        resp_d = {8'h00, rsp_i};
                    end else begin
                        resp_d[31:0] = rsp_i[31:0];
                    end
                    err_set[0]      = crc_error_i && crc_en_q;
                    err_set[1]      = end_bit_error_i;
                    err_set[2]      = index_error_i && idx_en_q;
                    status_set[5:3] = err_set;
                    status_set[0]   = 1'b1;
                    // A corrupted R1b response gives no trustworthy busy indication
                    if ((type_q == RSP_48_BUSY) && (err_set == 3'b000)) begin
                        dly_cnt_d = 16'd0;
                        state_d   = BUSY_DELAY;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            BUSY_DELAY: begin
                // Card is allowed a few SD clocks before it must drive DAT0 low
                if (dly_cnt_q >= BusyDelayW) begin
                    state_d = BUSY_WAIT;
`ifdef SDHCI_BUSY_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end else if (clk_en_p_i) begin
                    dly_cnt_d = dly_cnt_q + 16'd1;
                end
            end
            BUSY_WAIT: begin
                if (clk_en_p_i) begin
                    if (sd_bus_dat0_i) begin
                        status_set[1] = 1'b1;
                        state_d       = IDLE;
                    end
`ifdef SDHCI_BUSY_TIMEOUT_EN
                    else if (16'(tmo_cnt_q + 16'd1) == BusyTimeout) begin
                        status_set[6] = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Set wins over a simultaneous write-1-to-clear
        status_d = (status_q & ~status_clear_i) | status_set;

        // Software reset aborts the command but keeps the last response readable
        if (soft_rst_i) begin
            state_d  = IDLE;
            status_d = 7'h00;
            resp_d   = resp_q;
        end
    end

    // State and captured-data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            type_q    <= RSP_NONE;
            crc_en_q  <= 1'b0;
            idx_en_q  <= 1'b0;
            dly_cnt_q <= 16'd0;
            status_q  <= 7'h00;
            resp_q    <= 128'd0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            crc_en_q  <= crc_en_d;
            idx_en_q  <= idx_en_d;
            dly_cnt_q <= dly_cnt_d;
            status_q  <= status_d;
            resp_q    <= resp_d;
        end
    end

`ifdef SDHCI_BUSY_TIMEOUT_EN
    // Busy timeout tick counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign response_o = resp_q;
    assign status_o   = status_q;
    assign dat_busy_o = (state_q == BUSY_DELAY) || (state_q == BUSY_WAIT);

endmodule

// File: tb/tb_rsp_status_capture.sv
// Directed bench for rsp_status_capture with hand-computed expectations.
// Latency: checks sample #1 after the clock edge that follows each stimulus pulse.
// Backpressure: none; the DUT has no stall path.

module tb_rsp_status_capture;
    import sdhci_pkg::*;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           clk_en_p;
    logic           soft_rst;
    logic           cmd_start;
    response_type_e rtype;
    logic           crc_en;
    logic           idx_en;
    logic           cmd_done;
    logic           rsp_vld;
    logic [119:0]   rsp;
    logic           idx_err;
    logic           ebit_err;
    logic           crc_err;
    logic           tmo_err;
    logic           dat0;
    logic [6:0]     st_clr;
    logic [127:0]   response;
    logic [6:0]     status;
    logic           dat_busy;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [127:0]   exp_resp;
    logic [119:0]   r2_dat;
    logic [119:0]   r1_dat;

    always #5 clk = ~clk;

    rsp_status_capture #(
        .BusyDelay   (2),
        .BusyTimeout (16'd20)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .clk_en_p_i         (clk_en_p),
        .soft_rst_i         (soft_rst),
        .cmd_start_i        (cmd_start),
        .response_type_i    (rtype),
        .crc_check_en_i     (crc_en),
        .index_check_en_i   (idx_en),
        .cmd_done_i         (cmd_done),
        .cmd_result_valid_i (rsp_vld),
        .rsp_i              (rsp),
        .index_error_i      (idx_err),
        .end_bit_error_i    (ebit_err),
        .crc_error_i        (crc_err),
        .timeout_error_i    (tmo_err),
        .sd_bus_dat0_i      (dat0),
        .status_clear_i     (st_clr),
        .response_o         (response),
        .status_o           (status),
        .dat_busy_o         (dat_busy)
    );

    // A new command must never be issued while R1b busy is still pending
    always @(posedge clk) begin
        if (rst_ni && cmd_start) begin
            assert (!dat_busy) else $error("cmd_start issued while busy pending");
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] exp_st, input logic exp_busy);
        check_eq({tag, "/status"}, 128'(status), 128'(exp_st));
        check_eq({tag, "/busy"}, 128'(dat_busy), 128'(exp_busy));
        check_eq({tag, "/resp"}, response, exp_resp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input response_type_e t, input logic c_en, input logic i_en);
        cmd_start = 1'b1;
        rtype     = t;
        crc_en    = c_en;
        idx_en    = i_en;
        cyc();
        cmd_start = 1'b0;
        cyc();
    endtask

    task automatic send_result(input logic [119:0] r, input logic vld, input logic to,
                               input logic c_e, input logic e_e, input logic i_e);
        rsp      = r;
        rsp_vld  = vld;
        tmo_err  = to;
        crc_err  = c_e;
        ebit_err = e_e;
        idx_err  = i_e;
        cyc();
        rsp_vld  = 1'b0;
        tmo_err  = 1'b0;
        crc_err  = 1'b0;
        ebit_err = 1'b0;
        idx_err  = 1'b0;
    endtask

    task automatic sd_tick();
        clk_en_p = 1'b1;
        cyc();
        clk_en_p = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic clear_status(input logic [6:0] mask);
        st_clr = mask;
        cyc();
        st_clr = 7'h00;
    endtask

    initial begin
        rst_ni    = 1'b0;
        clk_en_p  = 1'b0;
        soft_rst  = 1'b0;
        cmd_start = 1'b0;
        rtype     = RSP_NONE;
        crc_en    = 1'b0;
        idx_en    = 1'b0;
        cmd_done  = 1'b0;
        rsp_vld   = 1'b0;
        rsp       = '0;
        idx_err   = 1'b0;
        ebit_err  = 1'b0;
        crc_err   = 1'b0;
        tmo_err   = 1'b0;
        dat0      = 1'b1;
        st_clr    = 7'h00;
        exp_resp  = '0;
        r2_dat    = 120'hAAAAAA_AAAAAA_AAAAAA_555555_555555;
        r1_dat    = {88'hFFFF_FFFF_FFFF_FFFF_FFFF_FF, 32'h0000_0900};

        repeat (3) cyc();
        check_all("reset", 7'h00, 1'b0);
        rst_ni = 1'b1;
        cyc();

        // R2: full 120-bit copy, top byte zero
        start_cmd(RSP_136, 1'b1, 1'b0);
        send_result(r2_dat, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_resp = {8'h00, r2_dat};
        check_all("r2", 7'h01, 1'b0);
        clear_status(7'h01);
        check_all("r2_clear", 7'h00, 1'b0);

        // R1: only the low word moves, upper response words untouched
        start_cmd(RSP_48, 1'b1, 1'b1);
        send_result(r1_dat, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_resp[31:0] = 32'h0000_0900;
        check_all("r1", 7'h01, 1'b0);
        repeat (4) sd_tick();
        check_eq("r1_no_busy", 128'(dat_busy), 128'd0);
        clear_status(7'h01);

        // No-response command completes on cmd_done
        start_cmd(RSP_NONE, 1'b0, 1'b0);
        cmd_done = 1'b1;
        cyc();
        cmd_done = 1'b0;
        check_all("noresp", 7'h01, 1'b0);
        clear_status(7'h7F);

        // Timeout alone, then timeout coinciding with a result
        start_cmd(RSP_48, 1'b1, 1'b1);
        send_result(120'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("timeout", 7'h04, 1'b0);
        clear_status(7'h04);
        start_cmd(RSP_48, 1'b1, 1'b1);
        send_result(120'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("timeout_and_vld", 7'h04, 1'b0);
        clear_status(7'h04);

        // CRC error masked by crc_check_en=0; set and clear in same cycle
        start_cmd(RSP_48, 1'b0, 1'b0);
        st_clr = 7'h01;
        send_result(120'hCAFE_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        st_clr = 7'h00;
        exp_resp[31:0] = 32'hCAFE_0001;
        check_all("crc_masked_set_wins", 7'h01, 1'b0);
        clear_status(7'h01);

        // End-bit error is never masked; index error honoured when enabled
        start_cmd(RSP_48, 1'b0, 1'b1);
        send_result(120'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_resp[31:0] = 32'h0000_0002;
        check_all("ebit_idx", 7'h31, 1'b0);
        clear_status(7'h7F);

        // R1b with CRC error: no busy phase
        start_cmd(RSP_48_BUSY, 1'b1, 1'b0);
        send_result(120'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_resp[31:0] = 32'h0000_0003;
        check_all("r1b_crc", 7'h09, 1'b0);
        repeat (3) sd_tick();
        check_eq("r1b_crc_no_busy", 128'(dat_busy), 128'd0);
        clear_status(7'h7F);

        // R1b: DAT0 low for 10 ticks then released
        start_cmd(RSP_48_BUSY, 1'b1, 1'b1);
        dat0 = 1'b0;
        send_result(120'h0000_0B00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_resp[31:0] = 32'h0000_0B00;
        check_all("r1b_result", 7'h01, 1'b1);
        repeat (10) sd_tick();
        check_all("r1b_low10", 7'h01, 1'b1);
        dat0 = 1'b1;
        clk_en_p = 1'b1;
        cyc();
        clk_en_p = 1'b0;
        check_all("r1b_release", 7'h03, 1'b0);
        clear_status(7'h7F);
        check_eq("r1b_cleared", 128'(status), 128'h0);

        // R1b with DAT0 stuck low
        start_cmd(RSP_48_BUSY, 1'b1, 1'b1);
        dat0 = 1'b0;
        send_result(120'h0000_0C00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_resp[31:0] = 32'h0000_0C00;
`ifdef SDHCI_BUSY_TIMEOUT_EN
        repeat (2 + 19) sd_tick();
        check_all("stuck_pre_timeout", 7'h01, 1'b1);
        sd_tick();
        check_all("stuck_timeout", 7'h41, 1'b0);
`else
        repeat (100) sd_tick();
        check_all("stuck_100", 7'h01, 1'b1);
`endif
        soft_rst = 1'b1;
        cyc();
        soft_rst = 1'b0;
        check_all("soft_rst", 7'h00, 1'b0);
        dat0 = 1'b1;

        // Engine is usable again after software reset
        start_cmd(RSP_48, 1'b1, 1'b1);
        send_result(120'h0000_0D00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_resp[31:0] = 32'h0000_0D00;
        check_all("after_soft_rst", 7'h01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsp_status_capture.md
Name: rsp_status_capture

Overview:
- Sits directly downstream of the SD command engine.
- Consumes each command's result:
  - moves the received response bits into the SDHCI Response register image with spec-correct alignment;
  - sets sticky command-related Normal/Error interrupt status bits;
  - for R1b (48-bit check-busy) responses, tracks DAT0 busy and raises Transfer Complete when the card releases the line.
- Register-file logic reads `response_o`/`status_o` and issues write-1-to-clear masks.

Parameters:
- BusyDelay, 2, SD clock ticks (`clk_en_p_i` pulses) after the response before DAT0 is first sampled for busy.
- BusyTimeout, 16'hFFFF, SD clock ticks allowed in busy before data timeout (used only with the optional feature).

Ports:
- `clk_i` input 1: system clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `clk_en_p_i` input 1: SD clock rising-edge enable, one `clk_i` cycle wide.
- `soft_rst_i` input 1: synchronous Software Reset for CMD line.
- `cmd_start_i` input 1: pulse when a command is accepted (valid && ready).
- `response_type_i` input `sdhci_pkg::response_type_e`: type of the accepted command; latched on `cmd_start_i`.
- `crc_check_en_i` input 1: Command CRC Check Enable; latched on `cmd_start_i`.
- `index_check_en_i` input 1: Command Index Check Enable; latched on `cmd_start_i`.
- `cmd_done_i` input 1: command transmission finished (pulse).
- `cmd_result_valid_i` input 1: response received (pulse).
- `rsp_i` input 120: received response bits; `rsp_i[n]` = R[n+8].
- `index_error_i`, `end_bit_error_i`, `crc_error_i` input 1 each: qualifiers, valid with `cmd_result_valid_i`.
- `timeout_error_i` input 1: response timeout (pulse).
- `sd_bus_dat0_i` input 1: DAT0 line.
- `status_clear_i` input 7: W1C mask for `status_o`.
- `response_o` output 128: Response register image (RESP0..RESP3).
- `status_o` output 7: sticky status bits, mapped as:
  - [0] cmd complete
  - [1] transfer complete
  - [2] cmd timeout err
  - [3] cmd CRC err
  - [4] cmd end-bit err
  - [5] cmd index err
  - [6] data timeout err
- `dat_busy_o` output 1: high while R1b busy is pending (feeds Command Inhibit DAT).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. `rst_ni` is asynchronous.
- `soft_rst_i` (synchronous, highest priority):
  - FSM to IDLE, `status_o` cleared, `dat_busy_o` 0.
  - `response_o` is retained.
- FSM states and transitions:
  - IDLE → WAIT_RESULT on `cmd_start_i`; latch type and the two enable bits.
  - WAIT_RESULT, NO_RESPONSE type: on `cmd_done_i` set status[0] → IDLE.
  - WAIT_RESULT, `timeout_error_i`: set status[2] only (no [0], no response update) → IDLE. Timeout has priority if it coincides with `cmd_result_valid_i`.
  - WAIT_RESULT, `cmd_result_valid_i`:
    - update `response_o`;
    - set status[3] if `crc_error_i && crc_check_en`;
    - set status[4] if `end_bit_error_i`;
    - set status[5] if `index_error_i && index_check_en`;
    - set status[0] unconditionally;
    - next state: BUSY_DELAY if type is 48_CHECK_BUSY and none of [3:5] were set this cycle, else IDLE.
  - BUSY_DELAY: count `clk_en_p_i` ticks; after BusyDelay ticks → BUSY_WAIT. `dat_busy_o` = 1.
  - BUSY_WAIT: on `clk_en_p_i` with `sd_bus_dat0_i` = 1, set status[1] → IDLE. `dat_busy_o` = 1.
- Response alignment:
  - 136-bit: `response_o[119:0]` = `rsp_i`, `[127:120]` = 0.
  - 48-bit types: `response_o[31:0]` = `rsp_i[31:0]`; `[127:32]` unchanged.
- Status write rules:
  - Per bit: set on the event cycle, cleared when `status_clear_i` bit = 1.
  - Set and clear in the same cycle: set wins.
  - Bits are sticky across commands; clearing a bit does not affect the FSM.
- `cmd_start_i` while not IDLE is ignored (protocol violation; assertion in bench).
- Latency: status and response updates are visible the cycle after the triggering pulse.

Optional Feature:
- Macro: `SDHCI_BUSY_TIMEOUT_EN`.
- Defined:
  - a 16-bit counter runs in BUSY_WAIT on each `clk_en_p_i`;
  - on reaching BusyTimeout: set status[6], no status[1], → IDLE.
- Undefined:
  - no counter; status[6] tied 0;
  - BUSY_WAIT waits indefinitely (`soft_rst_i` is the only exit).

Test Plan:
- R1 response, `rsp_i[31:0]`=32'h0000_0900, no errors → `response_o[31:0]`=32'h0000_0900, upper bits unchanged; `status_o`=7'h01; `dat_busy_o` stays 0.
- R2 response, `rsp_i`=120'hAA..55 → `response_o`=`{8'h00, rsp_i}`; `status_o`=7'h01; clear mask 7'h01 → `status_o`=0.
- Timeout → `status_o`=7'h04, `response_o` unchanged; same-cycle timeout and valid → 7'h04.
- R1b: DAT0 low for 10 ticks then high → `dat_busy_o` high from the result until the tick where DAT0 is seen high; `status_o`=7'h03.
- CRC error with `crc_check_en`=0 → 7'h01; with `crc_check_en`=1 → 7'h09 and no busy phase on R1b.
- R1b with BusyTimeout=20 and DAT0 held low:
  - with the macro → 7'h41 after 20 ticks;
  - without the macro → still busy after 100 ticks, `soft_rst_i` → `status_o`=0, `dat_busy_o`=0.
